vga_scanout: RTL and testbench

- Timing and output stage of the iTalos video path.
- Divides the system clock into a pixel strobe and runs horizontal and vertical raster counters.
- Publishes the current pixel coordinate to the upstream colour logic, and accepts its 9-bit `{R,G,B}` word in the same pixel period.
- Drives a registered, blanked RGB word with pixel-aligned hsync and vsync to the board DAC pins.

---
 rtl/vga_scanout_pkg.sv | 26 ++
 rtl/raster_counter.sv | 54 +++++
 rtl/vga_scanout.sv | 78 +++++++
 tb/tb_vga_scanout.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_scanout_pkg.sv
// Shared widths and default 640x480@60 raster timing for the iTalos video path.
// The colouriser imports the same package so both sides agree on pixel and coordinate widths.
package vga_scanout_pkg;

  localparam int CH_W    = 3;
  localparam int RGB_W   = 3 * CH_W;
  localparam int COORD_W = 10;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [RGB_W-1:0]   rgb_t;

  // Inclusive window test used for the sync pulse decode.
  function automatic logic in_window(coord_t c, coord_t lo, coord_t hi);
    return (c >= lo) && (c <= hi);
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Pixel-rate divider plus horizontal/vertical raster counters.
// Every counter advances only on pix_tick; h wraps at H_TOTAL-1 and carries into v.
module raster_counter
  import vga_scanout_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 525
) (
  input  logic   clk,
  input  logic   rst_n,
  output logic   pix_tick,
  output coord_t h_cnt,
  output coord_t v_cnt
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);

  logic [DIV_W-1:0] div_cnt;

  // NOTE: gating with rst_n keeps the strobe low while reset is held, even when
  // CLK_DIV=1 makes the divider compare permanently true.
  assign pix_tick = rst_n && (div_cnt == DIV_LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_tick) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_scanout.sv
// Timing and output stage: raster counters, active-area decode, blanking and
// pixel-aligned registered RGB/hsync/vsync toward the board DAC.
module vga_scanout
  import vga_scanout_pkg::*;
#(
  parameter int   CLK_DIV  = 2,
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [RGB_W-1:0]   RGB_in,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y,
  output logic               video_on,
  output logic               pix_tick,
  output logic               frame_start,
  output logic               hsync,
  output logic               vsync,
  output logic [RGB_W-1:0]   RGB_out
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam coord_t H_VIS = coord_t'(H_ACTIVE);
  localparam coord_t V_VIS = coord_t'(V_ACTIVE);
  localparam coord_t HS_LO = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_HI = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam coord_t VS_LO = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_HI = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);

  coord_t h_cnt;
  coord_t v_cnt;
  logic   hsync_active;
  logic   vsync_active;

  raster_counter #(
    .CLK_DIV (CLK_DIV),
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL)
  ) u_raster (
    .clk      (clk),
    .rst_n    (rst_n),
    .pix_tick (pix_tick),
    .h_cnt    (h_cnt),
    .v_cnt    (v_cnt)
  );

  assign pixel_x     = h_cnt;
  assign pixel_y     = v_cnt;
  assign video_on    = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign frame_start = pix_tick && (h_cnt == '0) && (v_cnt == '0);

  assign hsync_active = in_window(h_cnt, HS_LO, HS_HI);
  assign vsync_active = in_window(v_cnt, VS_LO, VS_HI);

  // Colour and syncs are captured on the same tick so they share one pixel of latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RGB_out <= '0;
      hsync   <= ~SYNC_POL;
      vsync   <= ~SYNC_POL;
    end else if (pix_tick) begin
      RGB_out <= video_on ? RGB_in : '0;
      hsync   <= hsync_active ? SYNC_POL : ~SYNC_POL;
      vsync   <= vsync_active ? SYNC_POL : ~SYNC_POL;
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// Self-checking bench for vga_scanout using a reduced raster so whole frames fit a short run.
// Expected values come from an elapsed-clock arithmetic model, not from the counter structure.
module tb_vga_scanout;

  localparam int D  = 2;
  localparam int HA = 16, HF = 4, HS = 6, HB = 6;
  localparam int VA = 12, VF = 2, VS = 2, VB = 4;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [8:0] rgb_in = '0;
  logic [9:0] pixel_x, pixel_y;
  logic       video_on, pix_tick, frame_start, hsync, vsync;
  logic [8:0] rgb_out;

  vga_scanout #(
    .CLK_DIV (D),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .RGB_in     (rgb_in),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .video_on   (video_on),
    .pix_tick   (pix_tick),
    .frame_start(frame_start),
    .hsync      (hsync),
    .vsync      (vsync),
    .RGB_out    (rgb_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: e = rising edges since reset release; position = completed ticks mod frame.
  bit         running;
  int         e;
  int         mode;
  bit         pend_valid, pend_hs, pend_vs;
  logic [8:0] pend_rgb;
  logic [8:0] m_rgb;
  bit         m_hs, m_vs;

  function automatic bit m_tick();
    return running && ((e % D) == D - 1);
  endfunction
  function automatic int m_pos();
    return (e / D) % FT;
  endfunction
  function automatic int m_h();
    return m_pos() % HT;
  endfunction
  function automatic int m_v();
    return m_pos() / HT;
  endfunction
  function automatic bit m_vis();
    return (m_h() < HA) && (m_v() < VA);
  endfunction

  task automatic model_reset();
    running = 0; e = 0; pend_valid = 0;
    m_rgb = '0; m_hs = 0; m_vs = 0;
  endtask

  task automatic drive_and_capture();
    case (mode)
      1:       rgb_in = 9'h1FF;
      2:       rgb_in = {pixel_x[2:0], 6'b0};
      default: rgb_in = 9'($urandom);
    endcase
    if (m_tick()) begin
      pend_valid = 1;
      pend_rgb   = m_vis() ? rgb_in : 9'h000;
      pend_hs    = (m_h() >= HA + HF) && (m_h() <= HA + HF + HS - 1);
      pend_vs    = (m_v() >= VA + VF) && (m_v() <= VA + VF + VS - 1);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    if (running) begin
      e++;
      if (pend_valid) begin
        m_rgb = pend_rgb; m_hs = pend_hs; m_vs = pend_vs;
      end
      pend_valid = 0;
    end
    @(negedge clk);
    drive_and_capture();
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    running = 1; e = 0;
    drive_and_capture();
  endtask

  task automatic test_reset();
    mode = 0;
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (pixel_x !== 10'd0 || pixel_y !== 10'd0 || pix_tick !== 1'b0 || frame_start !== 1'b0 ||
          rgb_out !== 9'h000 || hsync !== 1'b1 || vsync !== 1'b1)
      begin
        errors++;
        $display("FAIL reset_values x=%0d y=%0d tick=%b fs=%b rgb=%h hs=%b vs=%b, want 0 0 0 0 000 1 1",
                 pixel_x, pixel_y, pix_tick, frame_start, rgb_out, hsync, vsync);
      end
    end
    release_reset();
    for (int k = 1; k <= 8; k++) begin
      advance();
      checks++;
      if (pix_tick !== ((k % 2) == 1)) begin
        errors++;
        $display("FAIL release_tick edge=%0d got %b want %b", k, pix_tick, (k % 2) == 1);
      end
      if (k == 1 || k == 3) begin
        checks++;
        if (frame_start !== (k == 1)) begin
          errors++;
          $display("FAIL release_frame_start edge=%0d got %b want %b", k, frame_start, k == 1);
        end
      end
    end
  endtask

  task automatic test_random();
    mode = 0;
    for (int i = 0; i < 2 * FT * D; i++) begin
      advance();
      checks++;
      if (pixel_x !== 10'(m_h()) || pixel_y !== 10'(m_v())) begin
        errors++;
        $display("FAIL rand_coord e=%0d got (%0d,%0d) want (%0d,%0d)", e, pixel_x, pixel_y, m_h(), m_v());
      end
      checks++;
      if (video_on !== m_vis() || pix_tick !== m_tick()) begin
        errors++;
        $display("FAIL rand_flags e=%0d got von=%b tick=%b want %b %b", e, video_on, pix_tick, m_vis(), m_tick());
      end
      checks++;
      if (frame_start !== (m_tick() && m_pos() == 0)) begin
        errors++;
        $display("FAIL rand_frame_start e=%0d got %b want %b", e, frame_start, m_tick() && m_pos() == 0);
      end
      checks++;
      if (hsync !== !m_hs || vsync !== !m_vs || rgb_out !== m_rgb) begin
        errors++;
        $display("FAIL rand_outputs e=%0d got hs=%b vs=%b rgb=%h want %b %b %h",
                 e, hsync, vsync, rgb_out, !m_hs, !m_vs, m_rgb);
      end
    end
  endtask

  task automatic test_line_timing();
    int falls[$];
    int rise_at;
    int clk_n;
    logic prev;
    mode = 0;
    clk_n = 0; rise_at = -1;
    prev = hsync;
    while (falls.size() < 3 && clk_n < 5 * HT * D) begin
      advance();
      clk_n++;
      if (prev === 1'b1 && hsync === 1'b0) begin
        falls.push_back(clk_n);
        if (falls.size() == 1) begin
          checks++;
          if (pixel_x !== 10'(HA + HF + 1)) begin
            errors++;
            $display("FAIL hsync_start got pixel_x=%0d want %0d", pixel_x, HA + HF + 1);
          end
        end
      end
      if (prev === 1'b0 && hsync === 1'b1 && falls.size() == 1 && rise_at < 0) rise_at = clk_n;
      prev = hsync;
    end
    checks++;
    if (falls.size() < 3) begin
      errors++;
      $display("FAIL hsync_timeout got %0d falling edges want 3", falls.size());
    end else begin
      checks++;
      if (falls[1] - falls[0] != HT * D || falls[2] - falls[1] != HT * D) begin
        errors++;
        $display("FAIL hsync_period got %0d,%0d want %0d", falls[1] - falls[0], falls[2] - falls[1], HT * D);
      end
      checks++;
      if (rise_at - falls[0] != HS * D) begin
        errors++;
        $display("FAIL hsync_width got %0d want %0d", rise_at - falls[0], HS * D);
      end
    end
  endtask

  task automatic test_frame_timing();
    int falls[$];
    int rise_at;
    int clk_n;
    int fs_cnt;
    logic prev;
    mode = 0;
    clk_n = 0; rise_at = -1; fs_cnt = 0;
    prev = vsync;
    while (falls.size() < 3 && clk_n < 4 * FT * D) begin
      advance();
      clk_n++;
      if (falls.size() >= 1 && frame_start === 1'b1) fs_cnt++;
      if (prev === 1'b1 && vsync === 1'b0) begin
        falls.push_back(clk_n);
        if (falls.size() == 1) begin
          checks++;
          if (pixel_y !== 10'(VA + VF) || pixel_x !== 10'd1) begin
            errors++;
            $display("FAIL vsync_start got (%0d,%0d) want (1,%0d)", pixel_x, pixel_y, VA + VF);
          end
        end
      end
      if (prev === 1'b0 && vsync === 1'b1 && falls.size() == 1 && rise_at < 0) rise_at = clk_n;
      prev = vsync;
    end
    checks++;
    if (falls.size() < 3) begin
      errors++;
      $display("FAIL vsync_timeout got %0d falling edges want 3", falls.size());
    end else begin
      checks++;
      if (falls[1] - falls[0] != FT * D || falls[2] - falls[1] != FT * D) begin
        errors++;
        $display("FAIL vsync_period got %0d,%0d want %0d", falls[1] - falls[0], falls[2] - falls[1], FT * D);
      end
      checks++;
      if (rise_at - falls[0] != VS * HT * D) begin
        errors++;
        $display("FAIL vsync_width got %0d want %0d", rise_at - falls[0], VS * HT * D);
      end
      checks++;
      if (fs_cnt != 2) begin
        errors++;
        $display("FAIL frame_start_count got %0d want 2", fs_cnt);
      end
    end
  endtask

  task automatic test_blanking();
    int lit;
    int bad;
    mode = 1;
    advance();
    advance();
    lit = 0; bad = 0;
    for (int i = 0; i < FT * D; i++) begin
      advance();
      if (rgb_out === 9'h1FF) lit++;
      else if (rgb_out !== 9'h000) bad++;
    end
    checks++;
    if (lit != HA * VA * D || bad != 0) begin
      errors++;
      $display("FAIL blank_count got lit=%0d other=%0d want lit=%0d other=0", lit, bad, HA * VA * D);
    end
    mode = 2;
    for (int i = 0; i < 3 * HT * D; i++) begin
      advance();
      checks++;
      if (rgb_out !== m_rgb) begin
        errors++;
        $display("FAIL blank_pattern e=%0d got %h want %h", e, rgb_out, m_rgb);
      end
    end
    mode = 0;
  endtask

  task automatic test_wrap();
    int n;
    bit seen_fs;
    n = 0;
    while (!(pixel_x === 10'(HT - 1) && pixel_y === 10'(VT - 1) && pix_tick === 1'b1) && n < FT * D + 4) begin
      advance();
      n++;
    end
    checks++;
    if (n >= FT * D + 4) begin
      errors++;
      $display("FAIL wrap_timeout never reached (%0d,%0d)", HT - 1, VT - 1);
    end else begin
      advance();
      checks++;
      if (pixel_x !== 10'd0 || pixel_y !== 10'd0 || video_on !== 1'b1 || frame_start !== 1'b0) begin
        errors++;
        $display("FAIL wrap_origin got (%0d,%0d) von=%b fs=%b want (0,0) 1 0",
                 pixel_x, pixel_y, video_on, frame_start);
      end
      n = 0; seen_fs = 0;
      while (pix_tick !== 1'b1 && n < D + 1) begin
        advance();
        n++;
      end
      seen_fs = (frame_start === 1'b1);
      checks++;
      if (!seen_fs || pixel_x !== 10'd0 || pixel_y !== 10'd0) begin
        errors++;
        $display("FAIL wrap_frame_start got fs=%b at (%0d,%0d) want 1 at (0,0)", frame_start, pixel_x, pixel_y);
      end
    end
  endtask

  task automatic test_async_reset();
    int n;
    n = 0;
    while (!(pixel_x === 10'(HT / 2) && pixel_y === 10'(VT / 2)) && n < FT * D + 4) begin
      advance();
      n++;
    end
    checks++;
    if (n >= FT * D + 4) begin
      errors++;
      $display("FAIL areset_timeout never reached (%0d,%0d)", HT / 2, VT / 2);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (pixel_x !== 10'd0 || pixel_y !== 10'd0 || pix_tick !== 1'b0 || frame_start !== 1'b0 ||
        rgb_out !== 9'h000 || hsync !== 1'b1 || vsync !== 1'b1)
    begin
      errors++;
      $display("FAIL areset_values x=%0d y=%0d tick=%b fs=%b rgb=%h hs=%b vs=%b, want 0 0 0 0 000 1 1",
               pixel_x, pixel_y, pix_tick, frame_start, rgb_out, hsync, vsync);
    end
    model_reset();
    repeat (3) @(negedge clk);
    release_reset();
    for (int i = 0; i < 2 * HT * D; i++) begin
      advance();
      checks++;
      if (pixel_x !== 10'(m_h()) || pixel_y !== 10'(m_v()) || hsync !== !m_hs || rgb_out !== m_rgb) begin
        errors++;
        $display("FAIL areset_restart e=%0d got (%0d,%0d) hs=%b rgb=%h want (%0d,%0d) %b %h",
                 e, pixel_x, pixel_y, hsync, rgb_out, m_h(), m_v(), !m_hs, m_rgb);
      end
    end
  endtask

  initial begin
    test_reset();
    test_random();
    test_line_timing();
    test_frame_timing();
    test_blanking();
    test_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
